uart_tx_buffered: RTL and testbench

//  Parametrised UART transmitter with an input FIFO and a valid/ready write port.

---
 rtl/uart_tx_buffered.sv | 213 +++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO write port feeding a start/data/[parity]/stop framing FSM.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (default build has none).
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        tx_busy,
    output logic                        uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
    localparam logic [PTR_W:0]   FULL_LEVEL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [PTR_W:0]       level_reg;
    logic [PTR_W:0]       level_next;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    assign fifo_empty = (level_reg == '0);
    assign tx_ready   = (level_reg != FULL_LEVEL);
    assign push       = tx_valid && tx_ready;
    assign fifo_level = level_reg;

    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + 1'b1;
        end else if (pop && !push) begin
            level_next = level_reg - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

    // ---------------- framing FSM ----------------
    state_t               state_reg;
    state_t               state_next;
    logic [CNT_W-1:0]     baud_reg;
    logic [CNT_W-1:0]     baud_next;
    logic [BIT_W-1:0]     bit_reg;
    logic [BIT_W-1:0]     bit_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 txd_reg;
    logic                 txd_next;
    logic                 busy_reg;
    logic                 baud_done;

    assign baud_done = (baud_reg == BAUD_LAST);

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shift register is consumed by the data bits.
    logic parity_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            parity_reg <= 1'b0;
        end else if (pop) begin
            parity_reg <= (^fifo_mem[rd_ptr_reg]) ^ (PARITY_ODD != 0);
        end
    end
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = 1'b1;
        pop        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                baud_next = '0;
                bit_next  = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    state_next = S_START;
                end
            end
            S_START: begin
                txd_next = 1'b0;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                txd_next = shift_reg[0];
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == DATA_LAST) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                txd_next = parity_reg;
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == STOP_LAST) begin
                        bit_next = '0;
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            shift_next = fifo_mem[rd_ptr_reg];
                            state_next = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line and busy outputs are registered together so both lag the state by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= S_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            txd_reg   <= txd_next;
            busy_reg  <= (state_reg != S_IDLE);
        end
    end

    assign uart_txd = txd_reg;
    assign tx_busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: 8N1 instance with a frame monitor, plus a 7-bit/2-stop instance.
// Works with or without UART_TX_PARITY_EN defined.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1000000;
    localparam int UART_BPS = 100000;
    localparam int BPS      = CLK_FREQ / UART_BPS;
    localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F0 = (1 + 8 + PAR + 1) * BPS;
    localparam int F1 = (1 + 7 + PAR + 2) * BPS;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;

    logic       valid0 = 1'b0;
    logic [7:0] data0  = 8'h00;
    logic       ready0;
    logic [2:0] level0;
    logic       busy0;
    logic       txd0;

    logic       valid1 = 1'b0;
    logic [6:0] data1  = 7'h00;
    logic       ready1;
    logic [2:0] level1;
    logic       busy1;
    logic       txd1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_q[$];
    int start_q[$];
    bit m_active    = 1'b0;
    int m_word      = 0;
    int m_cyc       = 0;
    int frames_done = 0;
    int last_push   = 0;
    int stalls      = 0;

    uart_tx_buffered #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
    ) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .tx_valid(valid0), .tx_ready(ready0), .tx_data(data0),
        .fifo_level(level0), .tx_busy(busy0), .uart_txd(txd0)
    );

    uart_tx_buffered #(
        .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(7),
        .STOP_BITS(2), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)
    ) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .tx_valid(valid1), .tx_ready(ready1), .tx_data(data1),
        .fifo_level(level1), .tx_busy(busy1), .uart_txd(txd1)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Reference frame: bit period idx of a frame carrying word d.
    function automatic int frame_bit(input int d, input int nbits, input int odd, input int idx);
        if (idx == 0) return 0;
        if (idx <= nbits) return (d >> (idx - 1)) & 1;
        if (PAR == 1 && idx == nbits + 1) return ($countones(d & ((1 << nbits) - 1)) + odd) % 2;
        return 1;
    endfunction

    // Line monitor for dut0: every cycle of every frame is compared with the reference.
    initial begin
        int exp_bit;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                m_active = 1'b0;
                exp_q.delete();
            end else begin
                checks++;
                if (ready0 !== (level0 != 3'd4)) begin
                    errors++;
                    $display("FAIL ready_vs_level: ready=%b level=%0d", ready0, level0);
                end
                if (m_active) begin
                    exp_bit = frame_bit(m_word, 8, 0, m_cyc / BPS);
                    checks++;
                    if (txd0 !== exp_bit[0]) begin
                        errors++;
                        $display("FAIL line_bit: word=0x%02h cycle_in_frame=%0d txd=%b required=%0d",
                                 m_word, m_cyc, txd0, exp_bit);
                    end
                    m_cyc++;
                    if (m_cyc == F0) begin
                        m_active = 1'b0;
                        frames_done++;
                        $display("frame 0x%02h done, started at cycle %0d", m_word, start_q[$]);
                    end
                end else if (txd0 === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: txd=0 at cycle %0d required idle 1", cyc);
                    end else begin
                        m_word   = exp_q.pop_front();
                        m_active = 1'b1;
                        m_cyc    = 1;
                        start_q.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks begin and end on a falling clock edge.
    task automatic push0(input int d);
        int budget;
        budget = 0;
        valid0 = 1'b1;
        data0  = 8'(d);
        while (ready0 !== 1'b1 && budget < 2000) begin
            checks++;
            if (level0 !== 3'(DEPTH)) begin
                errors++;
                $display("FAIL stall_level: level=%0d required=%0d", level0, DEPTH);
            end
            stalls++;
            budget++;
            @(negedge sys_clk);
        end
        if (budget >= 2000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ready=%b required 1", ready0);
            valid0 = 1'b0;
            return;
        end
        @(negedge sys_clk);
        exp_q.push_back(d);
        last_push = cyc;
        $display("push 0x%02h accepted at cycle %0d", d, cyc);
    endtask

    task automatic wait_idle0(input int budget);
        int n;
        n = 0;
        valid0 = 1'b0;
        while (!(exp_q.size() == 0 && !m_active && busy0 === 1'b0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: pending=%0d busy=%b required 0/0", exp_q.size(), busy0);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #12;
        checks += 6;
        if (txd0 !== 1'b1)   begin errors++; $display("FAIL reset_txd: txd=%b required 1", txd0); end
        if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy0); end
        if (level0 !== 3'd0) begin errors++; $display("FAIL reset_level: level=%0d required 0", level0); end
        if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: ready=%b required 1", ready0); end
        if (txd1 !== 1'b1)   begin errors++; $display("FAIL reset_txd1: txd=%b required 1", txd1); end
        if (busy1 !== 1'b0)  begin errors++; $display("FAIL reset_busy1: busy=%b required 0", busy1); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_single();
        int p, n, f;
        f = frames_done;
        start_q.delete();
        push0(8'h55);
        p = last_push;
        valid0 = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 20) begin @(negedge sys_clk); n++; end
        checks++;
        if (start_q.size() == 0) begin
            errors++;
            $display("FAIL single_start: no start bit seen required within 20 cycles");
        end else begin
            if (start_q[0] - p != 2) begin
                errors++;
                $display("FAIL single_latency: push->txd fall=%0d required 2", start_q[0] - p);
            end
            n = 0;
            while (busy0 !== 1'b0 && n < F0 + 50) begin @(negedge sys_clk); n++; end
            checks++;
            if (cyc - start_q[0] != F0) begin
                errors++;
                $display("FAIL single_busy_fall: txd fall->busy fall=%0d required %0d", cyc - start_q[0], F0);
            end
        end
        wait_idle0(F0 + 50);
        checks++;
        if (frames_done - f != 1) begin
            errors++;
            $display("FAIL single_frames: frames=%0d required 1", frames_done - f);
        end
    endtask

    task automatic test_back_to_back();
        int p, f;
        int w [3];
        f = frames_done;
        start_q.delete();
        for (int i = 0; i < 3; i++) w[i] = $urandom_range(0, 255);
        push0(w[0]);
        p = last_push;
        checks++;
        if (level0 !== 3'd1) begin errors++; $display("FAIL b2b_level0: level=%0d required 1", level0); end
        push0(w[1]);
        checks++;
        if (level0 !== 3'd1) begin errors++; $display("FAIL b2b_level1: level=%0d required 1", level0); end
        push0(w[2]);
        checks++;
        if (level0 !== 3'd2) begin errors++; $display("FAIL b2b_level2: level=%0d required 2", level0); end
        valid0 = 1'b0;
        while (cyc < p + 1 + F0) @(negedge sys_clk);
        checks++;
        if (level0 !== 3'd1) begin errors++; $display("FAIL b2b_drain1: level=%0d required 1", level0); end
        while (cyc < p + 1 + 2 * F0) @(negedge sys_clk);
        checks++;
        if (level0 !== 3'd0) begin errors++; $display("FAIL b2b_drain0: level=%0d required 0", level0); end
        wait_idle0(2 * F0);
        checks++;
        if (frames_done - f != 3 || start_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_frames: frames=%0d required 3", frames_done - f);
        end else if (start_q[1] - start_q[0] != F0 || start_q[2] - start_q[1] != F0) begin
            errors++;
            $display("FAIL b2b_gap: spacing=%0d,%0d required %0d", start_q[1] - start_q[0],
                     start_q[2] - start_q[1], F0);
        end
    endtask

    task automatic test_overflow();
        int f;
        f = frames_done;
        stalls = 0;
        for (int i = 0; i < 6; i++) push0($urandom_range(0, 255));
        valid0 = 1'b0;
        checks++;
        if (stalls != F0 - 3) begin
            errors++;
            $display("FAIL overflow_stall: stall cycles=%0d required %0d", stalls, F0 - 3);
        end
        wait_idle0(7 * F0);
        checks++;
        if (frames_done - f != 6) begin
            errors++;
            $display("FAIL overflow_frames: frames=%0d required 6", frames_done - f);
        end
    endtask

    task automatic test_parity();
        int f;
        f = frames_done;
        push0(8'h07);
        wait_idle0(2 * F0);
        checks++;
        if (frames_done - f != 1) begin
            errors++;
            $display("FAIL parity_frames: frames=%0d required 1", frames_done - f);
        end
    endtask

    task automatic test_7n2();
        int p, s, n, e;
        valid1 = 1'b1;
        data1  = 7'h41;
        checks++;
        if (ready1 !== 1'b1) begin errors++; $display("FAIL n2_ready: ready=%b required 1", ready1); end
        @(negedge sys_clk);
        p = cyc;
        valid1 = 1'b0;
        $display("push 0x41 to 7-bit/2-stop instance at cycle %0d", p);
        n = 0;
        while (txd1 !== 1'b0 && n < 20) begin @(negedge sys_clk); n++; end
        s = cyc;
        checks++;
        if (s - p != 2) begin errors++; $display("FAIL n2_latency: push->txd fall=%0d required 2", s - p); end
        for (int i = 0; i < F1; i++) begin
            e = frame_bit(32'h41, 7, 1, i / BPS);
            checks++;
            if (txd1 !== e[0]) begin
                errors++;
                $display("FAIL n2_line: cycle_in_frame=%0d txd=%b required %0d", i, txd1, e);
            end
            if (i == F1 - 1) begin
                checks++;
                if (busy1 !== 1'b1) begin errors++; $display("FAIL n2_busy_hold: busy=%b required 1", busy1); end
            end
            @(negedge sys_clk);
        end
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL n2_busy_fall: busy=%b required 0", busy1); end
        $display("7-bit/2-stop frame 0x41 checked, %0d cycles", F1);
    endtask

    task automatic test_reset_mid();
        int n, f;
        start_q.delete();
        for (int i = 0; i < 3; i++) push0($urandom_range(0, 255));
        valid0 = 1'b0;
        n = 0;
        while (start_q.size() == 0 && n < 20) begin @(negedge sys_clk); n++; end
        if (start_q.size() != 0) begin
            while (cyc < start_q[0] + 4 * BPS + 5) @(negedge sys_clk);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        checks += 4;
        if (txd0 !== 1'b1)   begin errors++; $display("FAIL midrst_txd: txd=%b required 1", txd0); end
        if (busy0 !== 1'b0)  begin errors++; $display("FAIL midrst_busy: busy=%b required 0", busy0); end
        if (level0 !== 3'd0) begin errors++; $display("FAIL midrst_level: level=%0d required 0", level0); end
        if (ready0 !== 1'b1) begin errors++; $display("FAIL midrst_ready: ready=%b required 1", ready0); end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        $display("reset pulsed mid-frame, released at cycle %0d", cyc);
        @(negedge sys_clk);
        f = frames_done;
        push0(8'h12);
        wait_idle0(2 * F0);
        checks++;
        if (frames_done - f != 1) begin
            errors++;
            $display("FAIL midrst_frames: frames=%0d required 1", frames_done - f);
        end
    endtask

    task automatic test_random();
        int f, gap;
        f = frames_done;
        for (int i = 0; i < 16; i++) begin
            push0($urandom_range(0, 255));
            gap = $urandom_range(0, 3) == 0 ? $urandom_range(1, F0 + 20) : 0;
            if (gap > 0) begin
                valid0 = 1'b0;
                repeat (gap) @(negedge sys_clk);
            end
        end
        wait_idle0(6 * F0);
        checks++;
        if (frames_done - f != 16) begin
            errors++;
            $display("FAIL random_frames: frames=%0d required 16", frames_done - f);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_7n2();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
